// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg
// Shared definitions for the radix-2 DIT FFT sequencer:
//   - MAX_LOG_DEFAULT : default log2 of the largest transform size
//   - ENC_*           : controller state encodings
//   - state_t         : controller state type
//   - width_for()     : bits needed to hold values 0..max_value
package fft_ctrl_pkg;

    localparam int MAX_LOG_DEFAULT = 10;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_COMPUTE = 2'd1;
    localparam logic [1:0] ENC_GAP     = 2'd2;
    localparam logic [1:0] ENC_OUTPUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_COMPUTE = ENC_COMPUTE,
        ST_GAP     = ENC_GAP,
        ST_OUTPUT  = ENC_OUTPUT
    } state_t;

    function automatic int width_for(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/shift_register.sv
// shift_register
// Fixed-depth delay line with a synchronous clear.
//   clk  : clock
//   clr  : synchronous active-high clear, empties every stage
//   din  : data in (WIDTH bits)
//   dout : din delayed by DEPTH cycles
module shift_register #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH:0][WIDTH-1:0] chain;

    assign chain[0] = din;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = q_reg;
        end
    endgenerate

    assign dout = chain[DEPTH];

endmodule

// File: rtl/fft_seq_controller.sv
// fft_seq_controller
// Sequencer for an in-place radix-2 DIT FFT with runtime size 2^L.
// Per stage it issues one butterfly read per cycle, then waits BF_LAT idle
// cycles so that the stage's write-backs land before the next stage reads.
// After the final stage it streams natural-order output addresses.
//   clk, rst                : clock, synchronous active-high reset
//   start, cfg_log, cfg_inv : frame request, log2 size, inverse flag
//   cfg_err                 : pulse, start seen with out-of-range cfg_log
//   busy                    : frame in progress
//   rd_en, rd_addr_a/b      : butterfly operand reads
//   tw_addr, tw_conj        : twiddle ROM index (MAX_LOG-size ROM), conjugate
//   stage                   : current stage index
//   wr_en, wr_addr_a/b      : write-back, read signals delayed by BF_LAT
//   done                    : pulse, all stages written back
//   out_valid/ready/addr/last, frame_done : output address stream
module fft_seq_controller
    import fft_ctrl_pkg::*;
#(
    parameter int MAX_LOG = MAX_LOG_DEFAULT,
    parameter int BF_LAT  = 3,
    parameter int LW      = width_for(MAX_LOG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LW-1:0]      cfg_log,
    input  logic               cfg_inv,
    output logic               cfg_err,
    output logic               busy,
    output logic               rd_en,
    output logic [MAX_LOG-1:0] rd_addr_a,
    output logic [MAX_LOG-1:0] rd_addr_b,
    output logic [MAX_LOG-2:0] tw_addr,
    output logic               tw_conj,
    output logic [LW-1:0]      stage,
    output logic               wr_en,
    output logic [MAX_LOG-1:0] wr_addr_a,
    output logic [MAX_LOG-1:0] wr_addr_b,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_LOG-1:0] out_addr,
    output logic               out_last,
    output logic               frame_done
);

    localparam int GW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [GW-1:0]      GAP_LAST = GW'(BF_LAT - 1);
    localparam logic [MAX_LOG-1:0] ONE_A    = MAX_LOG'(1);
    localparam logic [LW-1:0]      ONE_S    = LW'(1);
    localparam logic [LW-1:0]      LOG_MAX  = LW'(MAX_LOG);
    localparam logic [LW-1:0]      TW_TOP   = LW'(MAX_LOG - 1);

    state_t             state_reg, state_next;
    logic [LW-1:0]      s_reg, s_next;
    logic [LW-1:0]      l_reg, l_next;
    logic [MAX_LOG-1:0] j_reg, j_next;
    logic [MAX_LOG-1:0] idx_reg, idx_next;
    logic [GW-1:0]      gap_reg, gap_next;
    logic               inv_reg, inv_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;
    logic               fdone_reg, fdone_next;

    logic [MAX_LOG-1:0] n_last;
    logic [MAX_LOG-1:0] j_last;
    logic [MAX_LOG-1:0] span;
    logic [MAX_LOG-1:0] pos;
    logic [MAX_LOG-1:0] addr_a;
    logic [MAX_LOG-1:0] addr_b;
    logic [MAX_LOG-1:0] tw_full;
    logic               cfg_ok;
    logic               start_ok;

    // N-1 wraps correctly for L = MAX_LOG (1<<MAX_LOG truncates to 0).
    assign n_last  = (ONE_A << l_reg) - ONE_A;
    assign j_last  = n_last >> 1;
    assign span    = ONE_A << s_reg;
    assign pos     = j_reg & (span - ONE_A);
    assign addr_a  = ((j_reg >> s_reg) << (s_reg + ONE_S)) | pos;
    assign addr_b  = addr_a + span;
    // Twiddle step is expressed in MAX_LOG-size units, so L never enters.
    assign tw_full = pos << (TW_TOP - s_reg);

    assign cfg_ok = (cfg_log != '0) && (cfg_log <= LOG_MAX);
    // The frame_done cycle is already IDLE, but a new frame may only be
    // accepted from the cycle after it.
    assign start_ok = start && !fdone_reg;

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        l_next     = l_reg;
        j_next     = j_reg;
        idx_next   = idx_reg;
        gap_next   = gap_reg;
        inv_next   = inv_reg;
        err_next   = 1'b0;
        done_next  = 1'b0;
        fdone_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    if (cfg_ok) begin
                        l_next     = cfg_log;
                        inv_next   = cfg_inv;
                        s_next     = '0;
                        j_next     = '0;
                        state_next = ST_COMPUTE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (j_reg == j_last) begin
                    gap_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    j_next = j_reg + ONE_A;
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    if (s_reg == l_reg - ONE_S) begin
                        done_next  = 1'b1;
                        idx_next   = '0;
                        state_next = ST_OUTPUT;
                    end else begin
                        s_next     = s_reg + ONE_S;
                        j_next     = '0;
                        state_next = ST_COMPUTE;
                    end
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    if (idx_reg == n_last) begin
                        fdone_next = 1'b1;
                        s_next     = '0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + ONE_A;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            l_reg     <= '0;
            j_reg     <= '0;
            idx_reg   <= '0;
            gap_reg   <= '0;
            inv_reg   <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            fdone_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            l_reg     <= l_next;
            j_reg     <= j_next;
            idx_reg   <= idx_next;
            gap_reg   <= gap_next;
            inv_reg   <= inv_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
            fdone_reg <= fdone_next;
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign rd_en      = (state_reg == ST_COMPUTE);
    // Addresses are forced to zero outside COMPUTE so the delay line
    // carries clean zeros alongside wr_en = 0.
    assign rd_addr_a  = rd_en ? addr_a : '0;
    assign rd_addr_b  = rd_en ? addr_b : '0;
    assign tw_addr    = rd_en ? tw_full[MAX_LOG-2:0] : '0;
    assign tw_conj    = inv_reg;
    assign stage      = s_reg;
    assign cfg_err    = err_reg;
    assign done       = done_reg;
    assign frame_done = fdone_reg;
    assign out_valid  = (state_reg == ST_OUTPUT);
    assign out_addr   = out_valid ? idx_reg : '0;
    assign out_last   = out_valid && (idx_reg == n_last);

    logic [2*MAX_LOG:0] wb_in;
    logic [2*MAX_LOG:0] wb_out;

    assign wb_in = {rd_en, rd_addr_a, rd_addr_b};

    shift_register #(
        .WIDTH (1 + 2 * MAX_LOG),
        .DEPTH (BF_LAT)
    ) u_wb_delay (
        .clk  (clk),
        .clr  (rst),
        .din  (wb_in),
        .dout (wb_out)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wb_out;

endmodule

// File: tb/tb_fft_seq_controller.sv
// tb_fft_seq_controller
// Randomized self-checking bench for fft_seq_controller. The reference model
// enumerates butterflies as textbook (stage, group, k) loops and derives the
// expected read/twiddle/write-back schedule and output stream from them.
module tb_fft_seq_controller;

    localparam int MAX_LOG = 10;
    localparam int BF_LAT  = 3;
    localparam int LW      = 4;
    localparam int MAXC    = 8192;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LW-1:0]      cfg_log;
    logic               cfg_inv;
    logic               cfg_err;
    logic               busy;
    logic               rd_en;
    logic [MAX_LOG-1:0] rd_addr_a;
    logic [MAX_LOG-1:0] rd_addr_b;
    logic [MAX_LOG-2:0] tw_addr;
    logic               tw_conj;
    logic [LW-1:0]      stage;
    logic               wr_en;
    logic [MAX_LOG-1:0] wr_addr_a;
    logic [MAX_LOG-1:0] wr_addr_b;
    logic               done;
    logic               out_valid;
    logic               out_ready;
    logic [MAX_LOG-1:0] out_addr;
    logic               out_last;
    logic               frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_en [MAXC];
    int exp_a  [MAXC];
    int exp_b  [MAXC];
    int exp_tw [MAXC];
    int exp_st [MAXC];

    fft_seq_controller #(
        .MAX_LOG (MAX_LOG),
        .BF_LAT  (BF_LAT),
        .LW      (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_log    (cfg_log),
        .cfg_inv    (cfg_inv),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_addr    (tw_addr),
        .tw_conj    (tw_conj),
        .stage      (stage),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cfg_err"},    int'(cfg_err), 0);
        check({tag, " busy"},       int'(busy), 0);
        check({tag, " rd_en"},      int'(rd_en), 0);
        check({tag, " rd_addr_a"},  int'(rd_addr_a), 0);
        check({tag, " rd_addr_b"},  int'(rd_addr_b), 0);
        check({tag, " tw_addr"},    int'(tw_addr), 0);
        check({tag, " tw_conj"},    int'(tw_conj), 0);
        check({tag, " stage"},      int'(stage), 0);
        check({tag, " wr_en"},      int'(wr_en), 0);
        check({tag, " done"},       int'(done), 0);
        check({tag, " out_valid"},  int'(out_valid), 0);
        check({tag, " out_addr"},   int'(out_addr), 0);
        check({tag, " out_last"},   int'(out_last), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
    endtask

    // Expected read schedule: stage s occupies a period of N/2 + BF_LAT
    // cycles starting at cycle 1; butterflies are issued group by group.
    task automatic build_model(input int L);
        int n;
        int per;
        n   = 1 << L;
        per = n / 2 + BF_LAT;
        for (int c = 0; c < MAXC; c++) begin
            exp_en[c] = 0;
            exp_a[c]  = 0;
            exp_b[c]  = 0;
            exp_tw[c] = 0;
            exp_st[c] = 0;
        end
        for (int s = 0; s < L; s++) begin
            int sp;
            sp = 1 << s;
            for (int g = 0; g < n / (2 * sp); g++) begin
                for (int k = 0; k < sp; k++) begin
                    int c;
                    c = 1 + s * per + g * sp + k;
                    exp_en[c] = 1;
                    exp_a[c]  = g * 2 * sp + k;
                    exp_b[c]  = g * 2 * sp + k + sp;
                    exp_tw[c] = k * ((1 << MAX_LOG) / (2 * sp));
                    exp_st[c] = s;
                end
            end
        end
    endtask

    task automatic maybe_inject(input int inject);
        if (inject != 0 && $urandom_range(0, 5) == 0) begin
            start   = 1'b1;
            cfg_log = LW'($urandom_range(0, 15));
            cfg_inv = 1'($urandom_range(0, 1));
        end else begin
            start = 1'b0;
        end
    endtask

    // mode 0: out_ready pattern 1,0,0,1 repeating; mode 1: random.
    task automatic run_frame(input int L, input int inv, input int mode, input int inject);
        int n;
        int t_done;
        int idx;
        int first;
        int pat;
        int guard;
        int rdy;
        int stalls;
        int pat_bits [4];
        pat_bits[0] = 1;
        pat_bits[1] = 0;
        pat_bits[2] = 0;
        pat_bits[3] = 1;

        build_model(L);
        n      = 1 << L;
        t_done = L * (n / 2 + BF_LAT) + 1;

        @(negedge clk);
        start     = 1'b1;
        cfg_log   = LW'(L);
        cfg_inv   = 1'(inv);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        for (int c = 1; c < t_done; c++) begin
            int w;
            w = (c > BF_LAT) ? exp_en[c - BF_LAT] : 0;
            check($sformatf("rd_en c%0d", c), int'(rd_en), exp_en[c]);
            if (exp_en[c] != 0) begin
                check($sformatf("rd_addr_a c%0d", c), int'(rd_addr_a), exp_a[c]);
                check($sformatf("rd_addr_b c%0d", c), int'(rd_addr_b), exp_b[c]);
                check($sformatf("tw_addr c%0d", c),   int'(tw_addr), exp_tw[c]);
                check($sformatf("stage c%0d", c),     int'(stage), exp_st[c]);
            end
            check($sformatf("wr_en c%0d", c), int'(wr_en), w);
            if (w != 0) begin
                check($sformatf("wr_addr_a c%0d", c), int'(wr_addr_a), exp_a[c - BF_LAT]);
                check($sformatf("wr_addr_b c%0d", c), int'(wr_addr_b), exp_b[c - BF_LAT]);
            end
            check($sformatf("busy c%0d", c),      int'(busy), 1);
            check($sformatf("done c%0d", c),      int'(done), 0);
            check($sformatf("out_valid c%0d", c), int'(out_valid), 0);
            check($sformatf("tw_conj c%0d", c),   int'(tw_conj), inv);
            maybe_inject(inject);
            @(negedge clk);
        end

        idx    = 0;
        first  = 1;
        pat    = 0;
        guard  = 0;
        stalls = 0;
        while (1) begin
            check($sformatf("out_valid i%0d", idx), int'(out_valid), 1);
            check($sformatf("out_addr i%0d", idx),  int'(out_addr), idx);
            check($sformatf("out_last i%0d", idx),  int'(out_last), (idx == n - 1) ? 1 : 0);
            check($sformatf("done i%0d", idx),      int'(done), first);
            check($sformatf("out busy i%0d", idx),  int'(busy), 1);
            check($sformatf("out rd_en i%0d", idx), int'(rd_en), 0);
            check($sformatf("out wr_en i%0d", idx), int'(wr_en), 0);
            check($sformatf("out tw_conj i%0d", idx), int'(tw_conj), inv);
            rdy = (mode == 0) ? pat_bits[pat % 4] : int'($urandom_range(0, 1));
            pat++;
            out_ready = 1'(rdy);
            maybe_inject(inject);
            @(negedge clk);
            first = 0;
            guard++;
            if (rdy != 0) begin
                if (idx == n - 1) break;
                idx++;
            end else begin
                stalls++;
            end
            if (guard > 16 * n + 16) begin
                check("output timeout", 1, 0);
                break;
            end
        end

        start     = 1'b0;
        out_ready = 1'b0;
        check("frame_done pulse", int'(frame_done), 1);
        check("busy at frame_done", int'(busy), 0);
        check("out_valid at frame_done", int'(out_valid), 0);
        check("done at frame_done", int'(done), 0);
        @(negedge clk);
        check("frame_done single", int'(frame_done), 0);
        check("busy after frame", int'(busy), 0);
        $display("frame L=%0d inv=%0d mode=%0d inject=%0d done_cycle=%0d stalls=%0d",
                 L, inv, mode, inject, t_done, stalls);
    endtask

    task automatic bad_cfg(input int value);
        @(negedge clk);
        start   = 1'b1;
        cfg_log = LW'(value);
        cfg_inv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("cfg_err pulse L=%0d", value), int'(cfg_err), 1);
        check($sformatf("cfg_err busy L=%0d", value),  int'(busy), 0);
        check($sformatf("cfg_err rd_en L=%0d", value), int'(rd_en), 0);
        @(negedge clk);
        check($sformatf("cfg_err clear L=%0d", value), int'(cfg_err), 0);
        check($sformatf("cfg_err idle L=%0d", value),  int'(busy), 0);
        check($sformatf("cfg_err no rd L=%0d", value), int'(rd_en), 0);
        $display("bad cfg_log=%0d rejected", value);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_log   = '0;
        cfg_inv   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        bad_cfg(0);
        bad_cfg(11);

        run_frame(3, 0, 0, 0);
        run_frame(3, 1, 0, 1);
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 7)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        // Reset in the middle of stage 1 of an L=4 frame (period 11 cycles).
        @(negedge clk);
        start   = 1'b1;
        cfg_log = LW'(4);
        cfg_inv = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre-reset stage", int'(stage), 1);
        check("pre-reset rd_en", int'(rd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid-frame reset");
        for (int i = 0; i < BF_LAT; i++) begin
            @(negedge clk);
            check($sformatf("flushed wr_en +%0d", i + 1), int'(wr_en), 0);
            check($sformatf("flushed busy +%0d", i + 1),  int'(busy), 0);
        end
        $display("mid-frame reset flushed");

        run_frame(10, int'($urandom_range(0, 1)), 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_seq_controller.md
# fft_seq_controller

Runtime-configurable sequencer for the in-place radix-2 DIT FFT datapath. It generates butterfly read addresses, twiddle addresses and write-back strobes for every stage of a 2^L-point transform, where L is selected per frame. It then streams natural-order output addresses under a ready/valid handshake. It sits between the frame loader, which writes samples bit-reversed, and the sample RAM / butterfly unit / output serializer. It generalises the fixed-size controller with runtime size, inverse mode, stage-gap hazard control and output backpressure.

## Interface
- MAX_LOG, 10, log2 of the largest supported FFT size; RAM depth is 2^MAX_LOG.
- BF_LAT, 3, butterfly pipeline latency in cycles, from read address to write-back; must be ≥1.
- LW, $clog2(MAX_LOG+1), width of cfg_log and stage.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- cfg_log  in  LW  log2 of transform size L for this frame; valid range 1..MAX_LOG.
- cfg_inv  in  1  1 = inverse transform (conjugate twiddles).
- cfg_err  out  1  one-cycle pulse when start is seen in IDLE with an invalid cfg_log.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- rd_en  out  1  butterfly operand read strobe.
- rd_addr_a, rd_addr_b  out  MAX_LOG  butterfly upper and lower operand addresses.
- tw_addr  out  MAX_LOG-1  twiddle ROM index, in 2^MAX_LOG units.
- tw_conj  out  1  latched cfg_inv.
- stage  out  LW  current stage index s.
- wr_en, wr_addr_a, wr_addr_b  out  1/MAX_LOG/MAX_LOG  write-back strobe and addresses; equal to rd_en and rd_addr_* delayed by BF_LAT.
- done  out  1  one-cycle pulse when all stages have been written back.
- out_valid  out  1  output address valid.
- out_ready  in  1  downstream accepts out_addr.
- out_addr  out  MAX_LOG  natural-order output read address.
- out_last  out  1  high with out_valid when out_addr = N-1.
- frame_done  out  1  one-cycle pulse on the cycle after the last output handshake.

## Operation
- States: IDLE, COMPUTE, GAP, OUTPUT.
- IDLE transitions:
  - start with valid cfg_log: latch L and cfg_inv, set s=0 and j=0, go to COMPUTE.
  - start with invalid cfg_log (0 or >MAX_LOG): pulse cfg_err and stay in IDLE.
- COMPUTE: one butterfly per cycle, j = 0..N/2-1 with N = 2^L.
  - span = 2^s, pos = j & (span-1).
  - rd_addr_a = ((j>>s)<<(s+1)) | pos; rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (MAX_LOG-1-s). This is independent of L, so one MAX_LOG-size ROM serves every size.
  - When j = N/2-1, go to GAP.
- GAP: BF_LAT idle cycles with rd_en=0, so the stage's writes land before the next stage reads.
  - Then, if s<L-1: s++, j=0, go to COMPUTE.
  - Otherwise: pulse done, go to OUTPUT with idx=0.
- OUTPUT:
  - out_valid=1, out_addr=idx.
  - idx increments only when out_valid&&out_ready.
  - The fire with idx=N-1 leaves OUTPUT; frame_done pulses in the next cycle, which is IDLE.
  - out_ready low holds out_addr stable indefinitely.
- Address bits above L-1 are always 0.
- start while busy is ignored; no queuing.
- rst in any state, mid-frame included, returns to IDLE next cycle. The write-back delay line is flushed, so no stale wr_en occurs.
- All outputs reset to 0.

## Timing
- start sampled at edge of cycle 0; busy and first rd_en in cycle 1.
- Stage s reads occupy cycles 1+s·(N/2+BF_LAT) through s·(N/2+BF_LAT)+N/2.
- Last write of a stage occurs exactly one cycle before the next stage's first read.
- done pulses in cycle L·(N/2+BF_LAT)+1; out_valid first high in the same cycle.
- wr_* lags rd_* by exactly BF_LAT cycles, including across stage boundaries.
- busy falls in the cycle frame_done pulses.
- A new start is accepted in the cycle after that, at the earliest.

## Structure
- Package fft_ctrl_pkg holds:
  - state encoding localparams (IDLE/COMPUTE/GAP/OUTPUT);
  - MAX_LOG default;
  - a bit-width helper function for LW.
- Sub-module: reuse the existing shift_register (width = 1+2·MAX_LOG, depth = BF_LAT) as the write-back delay line. It needs a synchronous active-high clear input added.
- Address/twiddle arithmetic stays inline, as combinational logic from registered s and j.

## Test plan
- L=3, MAX_LOG=10, BF_LAT=3, start -> rd pairs:
  - stage 0: (0,1),(2,3),(4,5),(6,7);
  - stage 1: (0,2),(1,3),(4,6),(5,7), tw 0,256,0,256;
  - stage 2: (0,4),(1,5),(2,6),(3,7), tw 0,128,256,384;
  - done in cycle 22.
- Same run -> every wr_en/wr_addr equals rd_* from 3 cycles earlier; no read in the cycle of or before a same-stage last write.
- cfg_log=0 and cfg_log=11 with start -> cfg_err pulse, busy stays 0, no rd_en.
- OUTPUT with out_ready toggling 1,0,0,1… -> out_addr 0..7 each held while stalled; out_last only with addr 7; frame_done one cycle after the final fire.
- rst asserted in stage 1 -> next cycle all outputs 0, no wr_en for the following BF_LAT cycles, new start with L=10 completes correctly.
- start pulsed during COMPUTE and OUTPUT, cfg_inv=1 -> ignored; tw_conj=1 throughout the frame.
